// File: rtl/ifq_pkg.sv
// ---------------------------------------------------------------------------
// ifq_pkg
// Shared definitions for the instruction-fetch prefetch queue.
//   ifq_state_t : fetch-request state
//                 IDLE = no request,
//                 REQ  = live request whose data will be queued,
//                 DROP = stale request whose data will be thrown away
//   PC_INCR     : byte distance between sequential instructions
// ---------------------------------------------------------------------------
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifq_state_t;

    localparam int PC_INCR = 4;

endpackage : ifq_pkg

// File: rtl/ifetch_prefetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with a synchronous flush.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   flush  in   empty the FIFO; dominates push and pop in the same cycle
//   push   in   write wdata at the tail (accepted if not full, or full and popping)
//   wdata  in   WIDTH-bit write data
//   pop    in   drop the head entry (ignored when empty)
//   rdata  out  head entry, combinational; zero while empty
//   empty  out  no entries held
//   full   out  DEPTH entries held
//   count  out  number of entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Masking the head while empty keeps stale or never-written storage
    // from reaching the outputs.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointers are PTR_W bits and DEPTH is a power of two, so increments
    // wrap modulo DEPTH on their own.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked by count/pointers,
    // which lets the array map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule : sync_fifo

// File: rtl/ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue
// Instruction-fetch front end sitting between I-Memory and the IF/ID register.
// Issues sequential fetches ahead of decode, buffers up to DEPTH {PC, instr}
// pairs and hands them to decode over a valid/ready handshake. A redirect
// flushes the queue and turns any outstanding request into a discarded one.
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   Redirect            flush and restart fetch at RedirectPC
//   RedirectPC          new fetch address (low two bits ignored)
//   InstrMemAck         I-Memory request complete, Instruction valid
//   Instruction         I-Memory read data
//   InstrMemReadEnable  request active (held until Ack)
//   PCForInstrMem       request address
//   OutValid/OutReady   decode handshake for the head entry
//   OutPC, OutInstr     head entry
//   Count               occupied entries
// ---------------------------------------------------------------------------
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       Redirect,
    input  logic [ADDR_W-1:0]          RedirectPC,
    input  logic                       InstrMemAck,
    input  logic [DATA_W-1:0]          Instruction,
    output logic                       InstrMemReadEnable,
    output logic [ADDR_W-1:0]          PCForInstrMem,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [ADDR_W-1:0]          OutPC,
    output logic [DATA_W-1:0]          OutInstr,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    ifq_state_t          state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   redirect_pc_aligned;
    logic                push;
    logic                pop;
    logic                fills_queue;
    logic                fifo_empty;
    logic                fifo_full;
    logic [ADDR_W+DATA_W-1:0] head;

    assign redirect_pc_aligned = RedirectPC & ~ADDR_W'(3);

    // Only a live request's data is queued, and a redirect in the same
    // cycle wins over both the push and the pop.
    assign push = (state == REQ) && InstrMemAck && !Redirect;
    assign pop  = OutValid && OutReady && !Redirect;

    // This Ack's push leaves the queue full unless decode pops alongside it.
    assign fills_queue = (Count == CNT_W'(DEPTH - 1)) && !pop;

    assign InstrMemReadEnable = (state != IDLE);
    assign PCForInstrMem      = fetch_pc;
    assign OutValid           = !fifo_empty;
    assign {OutPC, OutInstr}  = head;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else if (Redirect) begin
            fetch_pc <= redirect_pc_aligned;
            // A request still waiting for its Ack must be drained before
            // the new address can be issued; otherwise restart at once.
            if (state != IDLE && !InstrMemAck) state <= DROP;
            else                               state <= REQ;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_full) state <= REQ;
                end
                REQ: begin
                    if (InstrMemAck) begin
                        fetch_pc <= fetch_pc + ADDR_W'(PC_INCR);
                        if (fills_queue) state <= IDLE;
                    end
                end
                DROP: begin
                    if (InstrMemAck) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (Redirect),
        .push  (push),
        .wdata ({fetch_pc, Instruction}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (Count)
    );

endmodule : ifetch_prefetch_queue

// File: tb/tb_ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch_queue
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a queue-based reference model of the fetch front end.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrMemAck;
    logic [31:0] Instruction;
    logic        InstrMemReadEnable;
    logic [31:0] PCForInstrMem;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutPC;
    logic [31:0] OutInstr;
    logic [2:0]  Count;

    always #5 CLK = ~CLK;

    ifetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .Redirect           (Redirect),
        .RedirectPC         (RedirectPC),
        .InstrMemAck        (InstrMemAck),
        .Instruction        (Instruction),
        .InstrMemReadEnable (InstrMemReadEnable),
        .PCForInstrMem      (PCForInstrMem),
        .OutValid           (OutValid),
        .OutReady           (OutReady),
        .OutPC              (OutPC),
        .OutInstr           (OutInstr),
        .Count              (Count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_fetch;
    bit          m_active;   // a request is outstanding on the I-Memory port
    bit          m_stale;    // the outstanding request's data must be discarded

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be applied.
    task automatic model_update(input bit r, input bit rd, input logic [31:0] rpc,
                                input bit ack, input bit rdy, input logic [31:0] ins);
        bit     pop_m;
        bit     pushed;
        entry_t e;
        pushed = 1'b0;
        if (!r) begin
            mq.delete();
            m_fetch  = RESET_PC;
            m_active = 1'b0;
            m_stale  = 1'b0;
        end else if (rd) begin
            mq.delete();
            if (m_active && !ack) begin
                m_stale = 1'b1;
            end else begin
                m_active = 1'b1;
                m_stale  = 1'b0;
            end
            m_fetch = rpc & ~32'h3;
        end else begin
            pop_m = (mq.size() != 0) && rdy;
            if (!m_active) begin
                if (mq.size() < DEPTH) m_active = 1'b1;
            end else if (m_stale) begin
                if (ack) m_stale = 1'b0;
            end else if (ack) begin
                e.pc    = m_fetch;
                e.instr = ins;
                mq.push_back(e);
                m_fetch = m_fetch + 32'd4;
                pushed  = 1'b1;
            end
            if (pop_m) void'(mq.pop_front());
            if (pushed && mq.size() == DEPTH) m_active = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("read_enable", 64'(InstrMemReadEnable), 64'(m_active));
        check("req_pc",      64'(PCForInstrMem),      64'(m_fetch));
        check("out_valid",   64'(OutValid),           64'(mq.size() != 0));
        check("count",       64'(Count),              64'(mq.size()));
        if (mq.size() != 0) begin
            check("out_pc",    64'(OutPC),    64'(mq[0].pc));
            check("out_instr", 64'(OutInstr), 64'(mq[0].instr));
        end else begin
            check("out_pc_empty",    64'(OutPC),    64'd0);
            check("out_instr_empty", 64'(OutInstr), 64'd0);
        end
    endtask

    // Called at a negedge: apply inputs, cross one posedge, compare at the next negedge.
    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit ack, input bit rdy, input logic [31:0] ins);
        RST_N       = r;
        Redirect    = rd;
        RedirectPC  = rpc;
        InstrMemAck = ack;
        OutReady    = rdy;
        Instruction = ins;
        model_update(r, rd, rpc, ack, rdy, ins);
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
    endtask

    initial begin
        bit          r, rd, ack, rdy;
        logic [31:0] rpc;

        RST_N = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        InstrMemAck = 1'b0; Instruction = '0; OutReady = 1'b0;
        m_fetch = RESET_PC; m_active = 1'b0; m_stale = 1'b0;
        @(negedge CLK);

        // 1: streaming, one Ack per cycle, decode always ready
        do_reset();
        check("t1_reset_count", 64'(Count), 64'd0);
        check("t1_reset_ren",   64'(InstrMemReadEnable), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);     // IDLE -> REQ
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, $urandom);
            check("t1_stream_pc", 64'(OutPC), 64'(4 * i));
        end

        // 2: decode stalled, queue fills to DEPTH and fetch stops
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        check("t2_full_count", 64'(Count), 64'd4);
        check("t2_full_ren",   64'(InstrMemReadEnable), 64'd0);
        check("t2_head_pc",    64'(OutPC), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, $urandom);     // one pop
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        check("t2_refetch_ren", 64'(InstrMemReadEnable), 64'd1);
        check("t2_refetch_pc",  64'(PCForInstrMem), 64'd16);

        // 3: redirect while a request is outstanding, late Ack discarded
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, $urandom);     // request at 8 pending
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, $urandom);
        check("t3_flush_count", 64'(Count), 64'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF); // late Ack
        check("t3_late_dropped", 64'(Count), 64'd0);
        check("t3_next_req",     64'(PCForInstrMem), 64'h100);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
        check("t3_first_pc", 64'(OutPC), 64'h100);

        // 4: redirect coincides with Ack and pop
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, $urandom);
        check("t4_count",  64'(Count), 64'd0);
        check("t4_req_pc", 64'(PCForInstrMem), 64'h100);

        // 5: unaligned redirect near the top of the address space wraps
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, $urandom);
        check("t5_aligned", 64'(PCForInstrMem), 64'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        check("t5_wrap",    64'(PCForInstrMem), 64'h0);
        check("t5_head_pc", 64'(OutPC), 64'hFFFF_FFFC);

        // 6: reset during an outstanding request, Ack arrives afterwards
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, $urandom);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        check("t6_count",  64'(Count), 64'd0);
        check("t6_req_pc", 64'(PCForInstrMem), 64'(RESET_PC));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            r   = ($urandom_range(0, 299) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            ack = m_active ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            step(r, rd, rpc, ack, rdy, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ifetch_prefetch_queue
